// File: rtl/imem_loader.sv
// Streams big-endian program bytes into instruction memory one 32-bit word at a time,
// holding the CPU stalled until the requested number of words has been written.
module imem_loader #(
    parameter int NWORDS_MAX = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_we,
    output logic [7:0]  im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done
);

    localparam logic [6:0] NMAX = 7'(NWORDS_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e      state_q;
    logic [5:0]  word_addr_q;
    logic [1:0]  byte_idx_q;
    logic [6:0]  remain_q;
    logic [31:0] asm_q;
    logic [31:0] asm_d;
    logic [7:0]  im_addr_q;
    logic [31:0] im_wdata_q;
    logic [6:0]  n_clamped;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        asm_d = asm_q;
        case (byte_idx_q)
            2'd0:    asm_d[31:24] = byte_data;
            2'd1:    asm_d[23:16] = byte_data;
            2'd2:    asm_d[15:8]  = byte_data;
            default: asm_d[7:0]   = byte_data;
        endcase
        n_clamped = (num_words > NMAX) ? NMAX : num_words;
    end

    // Moore outputs: control strobes decode the state, write address/data are registers.
    assign byte_ready = (state_q == RECV);
    assign busy       = (state_q == RECV) || (state_q == WRITE);
    assign im_we      = (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign cpu_hold   = (state_q != DONE);
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;

    // NOTE: sequential state uses non-blocking assignments only; reset clears every register
    // so an aborted load leaves no partial word behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            word_addr_q <= '0;
            byte_idx_q  <= '0;
            remain_q    <= '0;
            asm_q       <= '0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        word_addr_q <= '0;
                        byte_idx_q  <= '0;
                        remain_q    <= n_clamped;
                        state_q     <= (n_clamped == 7'd0) ? DONE : RECV;
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        asm_q      <= asm_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            // Capture the write beat here so it is stable for the whole WRITE cycle.
                            im_addr_q  <= {word_addr_q, 2'b00};
                            im_wdata_q <= asm_d;
                            state_q    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    word_addr_q <= word_addr_q + 6'd1;
                    remain_q    <= remain_q - 7'd1;
                    state_q     <= (remain_q == 7'd1) ? DONE : RECV;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have one parameter: NWORDS_MAX, default 64, the instruction-memory capacity in 32-bit words (byte address space 256).
REQ-002 The module SHALL have the following port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The module SHALL have the following port: reset  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have the following port: start  input  1  request to begin a load; sampled on the rising edge.
REQ-005 The module SHALL have the following port: num_words  input  7  number of words to load (0..64); sampled when start is accepted.
REQ-006 The module SHALL have the following port: byte_valid  input  1  source presents a program byte.
REQ-007 The module SHALL have the following port: byte_data  input  8  program byte, in big-endian stream order.
REQ-008 The module SHALL have the following port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 The module SHALL have the following port: im_we  output  1  instruction-memory write strobe, one word per pulse.
REQ-010 The module SHALL have the following port: im_addr  output  8  instruction-memory byte address, word aligned.
REQ-011 The module SHALL have the following port: im_wdata  output  32  assembled instruction word.
REQ-012 The module SHALL have the following port: cpu_hold  output  1  holds the PA_RISC fetch and pipeline stalled while high.
REQ-013 The module SHALL have the following port: busy  output  1  a load is in progress.
REQ-014 The module SHALL have the following port: done  output  1  the last load completed; the program is runnable.

Function
REQ-015 The loader SHALL be a four-state Moore FSM with states IDLE, RECV, WRITE and DONE, and all outputs SHALL be registered or decoded from the state only.
REQ-016 In IDLE, the loader SHALL drive byte_ready=0, im_we=0, busy=0, done=0 and cpu_hold=1.
REQ-017 In IDLE, start=1 with num_words≠0 SHALL cause entry to RECV, latch num_words, and clear the word address and byte index to 0.
REQ-018 In IDLE, start=1 with num_words=0 SHALL cause entry to DONE directly, with no memory write.
REQ-019 A num_words value greater than NWORDS_MAX SHALL be clamped to NWORDS_MAX.
REQ-020 In RECV, the loader SHALL drive byte_ready=1 and busy=1, and a byte is accepted only on a cycle where byte_valid=1 and byte_ready=1.
REQ-021 Accepted bytes SHALL be placed big-endian: byte 0 into bits 31:24, byte 1 into 23:16, byte 2 into 15:8 and byte 3 into 7:0.
REQ-022 byte_valid=0 in RECV SHALL be a stall: no state change, and the partial word is held.
REQ-023 On acceptance of byte 3, the loader SHALL enter WRITE on the next edge.
REQ-024 WRITE SHALL last exactly one cycle, driving im_we=1, im_addr={word_addr[5:0],2'b00}, im_wdata equal to the assembled word, and byte_ready=0.
REQ-025 Leaving WRITE, the loader SHALL increment word_addr and decrement the remaining count.
REQ-026 Leaving WRITE, the loader SHALL enter DONE if the remaining count reaches 0, and RECV otherwise.
REQ-027 Throughput SHALL be at most 1 word per 5 cycles, with im_we asserted exactly 1 cycle after the 4th byte handshake.
REQ-028 word_addr SHALL wrap from 63 to 0, although it cannot be reached beyond a clamped load.
REQ-029 In DONE, the loader SHALL drive done=1, cpu_hold=0, busy=0 and byte_ready=0, and SHALL remain in DONE indefinitely.
REQ-030 start=1 in DONE SHALL begin a reload: enter RECV, reassert cpu_hold=1 on the next cycle, and clear done.
REQ-031 start asserted in RECV or WRITE SHALL be ignored.
REQ-032 im_we SHALL be 0 in every state other than WRITE, and im_addr and im_wdata SHALL hold their last values outside WRITE.

Reset
REQ-033 reset=0 SHALL asynchronously force IDLE and clear word_addr, the byte index, the remaining count and the assembly register.
REQ-034 While reset=0, the outputs SHALL be byte_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0 and cpu_hold=1.
REQ-035 A reset asserted mid-load, including during WRITE, SHALL abort the load with no further im_we pulse, and any partial word SHALL be discarded.
REQ-036 After the release of reset, the loader SHALL wait for a new start.

Verification
REQ-037 The bench SHALL cover a single-word load: start, num_words=1, then bytes 0x08,0x00,0x02,0x40 with byte_valid held high -> one im_we pulse with addr 0x00, wdata 0x08000240, then done=1 and cpu_hold=0.
REQ-038 The bench SHALL cover a three-word load with byte_valid toggled every other cycle -> writes at addrs 0x00, 0x04 and 0x08 with the correct words, and no acceptance while byte_valid=0.
REQ-039 The bench SHALL cover num_words=0 -> DONE the cycle after start, and im_we never asserted.
REQ-040 The bench SHALL cover reset pulsed low after 2 bytes of word 1 -> no im_we, state IDLE and cpu_hold=1; a new load of 1 word then writes addr 0x00 with only the new bytes.
REQ-041 The bench SHALL cover start pulsed during RECV, then a reload from DONE with num_words=2 -> the mid-load start is ignored; on reload, done drops, cpu_hold rises, and addrs 0x00 and 0x04 are rewritten.
REQ-042 The bench SHALL cover num_words=100 -> exactly 64 writes, with the final write at addr 0xFC, then DONE.
